// File: rtl/rr_mux_nx1.sv
// Round-robin N:1 multiplexer with per-channel valid/ready and a registered output stage.
// Optional feature macro: RR_MUX_FORCE_SEL_EN adds force_en/force_sel to pin the grant to one channel.
module rr_mux_nx1 #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
`ifdef RR_MUX_FORCE_SEL_EN
  input  logic                     force_en,
  input  logic [SEL_W-1:0]         force_sel,
`endif
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] ptr_next;
  logic             gnt_any;
  logic             forced;
  logic             load_ok;
  logic             load;
  int               idx;

  assign load_ok = !out_valid || out_ready;
  assign load    = load_ok && gnt_any;

  // Walk offsets from the far end back toward ptr so the closest requester wins.
  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin : grant_search
    grant   = '0;
    gnt_any = 1'b0;
    forced  = 1'b0;
    idx     = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (in_valid[SEL_W'(idx)]) begin
        grant   = SEL_W'(idx);
        gnt_any = 1'b1;
      end
    end
`ifdef RR_MUX_FORCE_SEL_EN
    if (force_en) begin
      forced = 1'b1;
      if (int'(force_sel) < NUM_CH) begin
        grant   = force_sel;
        gnt_any = in_valid[force_sel];
      end else begin
        grant   = '0;
        gnt_any = 1'b0;
      end
    end
`endif
  end

  assign ptr_next = (int'(grant) == NUM_CH - 1) ? '0 : grant + SEL_W'(1);

  always_comb begin
    in_ready = '0;
    if (rst_n && load) in_ready[grant] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant)*DATA_W +: DATA_W];
      out_sel   <= grant;
      if (!forced) ptr <= ptr_next;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Self-checking bench for rr_mux_nx1: a reference model pushes each expected grant into a
// scoreboard queue, popped and compared when the registered output updates.
module tb_rr_mux_nx1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
`ifdef RR_MUX_FORCE_SEL_EN
  logic        force_en;
  logic [2:0]  force_sel;
`endif

  int checks = 0;
  int errors = 0;

  logic [2:0]  m_ptr   = '0;
  logic        m_valid = 1'b0;
  logic [7:0]  m_data  = '0;
  logic [2:0]  m_sel   = '0;
  logic [10:0] sb_q[$];

  rr_mux_nx1 #(.NUM_CH(8), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef RR_MUX_FORCE_SEL_EN
    .force_en (force_en),
    .force_sel(force_sel),
`endif
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] data_of(input logic [2:0] k);
    return 8'h10 + {5'b0, k};
  endfunction

  function automatic void model_grant(input logic [7:0] v, output logic [2:0] g,
                                      output logic any, output logic frc);
    int idx;
    g   = '0;
    any = 1'b0;
    frc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(m_ptr) + i) % 8;
      if (!any && v[idx]) begin
        any = 1'b1;
        g   = 3'(idx);
      end
    end
`ifdef RR_MUX_FORCE_SEL_EN
    if (force_en) begin
      frc = 1'b1;
      g   = force_sel;
      any = v[force_sel];
    end
`endif
  endfunction

  // One clock of stimulus; entered and left at the falling edge.
  task automatic cycle(input logic [7:0] v, input logic rdy, input logic rstn);
    logic [2:0]  g;
    logic        any;
    logic        frc;
    logic        ld;
    logic [7:0]  exp_rdy;
    logic [10:0] item;
    in_valid  = v;
    out_ready = rdy;
    rst_n     = rstn;
    #1;
    model_grant(v, g, any, frc);
    ld      = rstn && (!m_valid || rdy) && any;
    exp_rdy = ld ? (8'b1 << g) : 8'h00;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready got=%h exp=%h (in_valid=%h)", in_ready, exp_rdy, v);
    end
    if (ld) sb_q.push_back({g, data_of(g)});
    @(posedge clk);
    if (!rstn) begin
      m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = '0;
    end else if (ld) begin
      m_valid = 1'b1; m_sel = g; m_data = data_of(g);
      if (!frc) m_ptr = g + 3'd1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
    if (ld) begin
      item = sb_q.pop_front();
      checks++;
      if ({out_sel, out_data} !== item || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL sb_word got sel=%0d data=%h valid=%b exp sel=%0d data=%h valid=1",
                 out_sel, out_data, out_valid, item[10:8], item[7:0]);
      end
    end
    checks++;
    if (out_valid !== m_valid || out_sel !== m_sel || out_data !== m_data) begin
      errors++;
      $display("FAIL out_state got v=%b sel=%0d data=%h exp v=%b sel=%0d data=%h",
               out_valid, out_sel, out_data, m_valid, m_sel, m_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(8'hFF, 1'b1, 1'b0);
    cycle(8'hFF, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0 || in_ready !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got v=%b data=%h sel=%0d rdy=%h exp v=0 data=00 sel=0 rdy=00",
               out_valid, out_data, out_sel, in_ready);
    end
    cycle(8'hFF, 1'b1, 1'b1);
    checks++;
    if (out_sel !== 3'd0 || out_data !== 8'h10) begin
      errors++;
      $display("FAIL reset_first_grant got sel=%0d data=%h exp sel=0 data=10", out_sel, out_data);
    end
  endtask

  task automatic test_round_robin();
    cycle(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cycle(8'hFF, 1'b1, 1'b1);
      checks++;
      if (out_sel !== 3'(i % 8) || out_data !== 8'(8'h10 + i % 8) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_seq[%0d] got sel=%0d data=%h exp sel=%0d data=%h",
                 i, out_sel, out_data, i % 8, 8'h10 + i % 8);
      end
    end
  endtask

  task automatic test_skip_wrap();
    logic [2:0] exp_s[3];
    exp_s = '{3'd0, 3'd2, 3'd0};
    cycle(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(8'h05, 1'b1, 1'b1);
      checks++;
      if (out_sel !== exp_s[i] || out_data !== data_of(exp_s[i])) begin
        errors++;
        $display("FAIL skip_wrap[%0d] got sel=%0d data=%h exp sel=%0d data=%h",
                 i, out_sel, out_data, exp_s[i], data_of(exp_s[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    cycle(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(8'hFF, 1'b0, 1'b1);
      checks++;
      if (in_ready !== 8'h00 || out_data !== 8'h13 || out_sel !== 3'd3 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d] got rdy=%h data=%h sel=%0d v=%b exp rdy=00 data=13 sel=3 v=1",
                 i, in_ready, out_data, out_sel, out_valid);
      end
    end
    cycle(8'hFF, 1'b1, 1'b1);
    checks++;
    if (out_sel !== 3'd4 || out_data !== 8'h14) begin
      errors++;
      $display("FAIL bp_release got sel=%0d data=%h exp sel=4 data=14", out_sel, out_data);
    end
    cycle(8'hFF, 1'b1, 1'b1);
    checks++;
    if (out_sel !== 3'd5 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back got sel=%0d v=%b exp sel=5 v=1", out_sel, out_valid);
    end
  endtask

  task automatic test_drain();
    cycle(8'h00, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h15 || out_sel !== 3'd5) begin
      errors++;
      $display("FAIL drain got v=%b data=%h sel=%0d exp v=0 data=15 sel=5",
               out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_mid_reset();
    cycle(8'hF0, 1'b1, 1'b1);
    cycle(8'hFF, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_valid got %b exp 0", out_valid);
    end
    cycle(8'hFF, 1'b1, 1'b1);
    checks++;
    if (out_sel !== 3'd0) begin
      errors++;
      $display("FAIL mid_reset_ptr got sel=%0d exp 0", out_sel);
    end
  endtask

`ifdef RR_MUX_FORCE_SEL_EN
  task automatic test_force();
    cycle(8'hFF, 1'b1, 1'b0);
    force_en  = 1'b1;
    force_sel = 3'd5;
    for (int i = 0; i < 3; i++) begin
      cycle(8'hFF, 1'b1, 1'b1);
      checks++;
      if (out_sel !== 3'd5 || out_data !== 8'h15) begin
        errors++;
        $display("FAIL force_sel[%0d] got sel=%0d data=%h exp sel=5 data=15", i, out_sel, out_data);
      end
    end
    force_en = 1'b0;
    cycle(8'hFF, 1'b1, 1'b1);
    checks++;
    if (out_sel !== 3'd0) begin
      errors++;
      $display("FAIL force_ptr_kept got sel=%0d exp 0", out_sel);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      cycle(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) != 0));
  endtask

  initial begin
    for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'(8'h10 + k);
    in_valid  = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
`ifdef RR_MUX_FORCE_SEL_EN
    force_en  = 1'b0;
    force_sel = '0;
`endif
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_drain();
    test_mid_reset();
`ifdef RR_MUX_FORCE_SEL_EN
    test_force();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
